// File: rtl/core_pkg.sv
// core_pkg: shared width, arbiter state and owner encodings
package core_pkg;
    localparam int XLEN = 32;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store with anti-starvation
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            if_flush_i,
    input  logic            d_req_valid_i,
    output logic            d_req_ready_o,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic            d_we_i,
    input  logic [3:0]      d_be_i,
    output logic            d_rsp_valid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    import core_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic          drop;
    logic          idle, fetch_win, data_win, hs;

    // Grant: data normally wins, fetch is forced through once it has lost LIM times
    always_comb begin
        idle            = state == IDLE;
        fetch_win       = if_req_valid_i & (!d_req_valid_i | starve_cnt == LIM);
        data_win        = d_req_valid_i & !fetch_win;
        mem_req_valid_o = idle & (if_req_valid_i | d_req_valid_i);
        hs              = mem_req_valid_o & mem_req_ready_i;
        if_req_ready_o  = idle & fetch_win & mem_req_ready_i;
        d_req_ready_o   = idle & data_win & mem_req_ready_i;
        mem_addr_o      = fetch_win ? if_addr_i : d_addr_i;
        mem_wdata_o     = fetch_win ? '0 : d_wdata_i;
        mem_we_o        = fetch_win ? 1'b0 : d_we_i;
        mem_be_o        = fetch_win ? 4'hF : d_be_i;
    end

    // FSM, starvation counter, flush-drop flag and registered responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_IF;
            starve_cnt     <= '0;
            drop           <= 1'b0;
            if_rsp_valid_o <= 1'b0;
            d_rsp_valid_o  <= 1'b0;
            if_rdata_o     <= '0;
            d_rdata_o      <= '0;
        end else begin
            if_rsp_valid_o <= 1'b0;
            d_rsp_valid_o  <= 1'b0;
            if (idle) begin
                if (hs) begin
                    state      <= BUSY;
                    owner      <= fetch_win ? OWN_IF : OWN_D;
                    starve_cnt <= fetch_win ? '0 :
                                  (if_req_valid_i && starve_cnt != LIM) ? starve_cnt + 1'b1 : starve_cnt;
                end
            end else if (mem_rsp_valid_i) begin
                state <= IDLE;
                drop  <= 1'b0;
                if (owner == OWN_D) begin
                    d_rsp_valid_o <= 1'b1;
                    d_rdata_o     <= mem_rdata_i;
                end else if (!(drop | if_flush_i)) begin
                    if_rsp_valid_o <= 1'b1;
                    if_rdata_o     <= mem_rdata_i;
                end
            end else if (owner == OWN_IF && if_flush_i) begin
                drop <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized model check
module tb_mem_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid_i, if_req_ready_o, if_rsp_valid_o, if_flush_i;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        d_req_valid_i, d_req_ready_o, d_we_i, d_rsp_valid_o;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [3:0]  d_be_i, mem_be_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int passed = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o), .if_addr_i(if_addr_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rdata_o(if_rdata_o), .if_flush_i(if_flush_i),
        .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
        .d_rsp_valid_o(d_rsp_valid_o), .d_rdata_o(d_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifv, dv, we, rdy;
        logic [3:0]  be;
        logic        e_valid, e_ifr, e_dr, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        if_req_valid_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        d_req_valid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_we_i = 1'b0; d_be_i = 4'h0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    // one memory response in the cycle after issue
    task automatic respond(input logic [31:0] data);
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = data;
        tick();
        mem_rsp_valid_i = 1'b0;
        settle();
    endtask

    vec_t vt[7];

    // random-phase reference model
    int m_busy, m_owner, m_starve, m_drop, mo, lat;
    logic e_ifp, e_dp, if_hold, d_hold, fw, dw, ev, hs;
    logic [31:0] e_ifd, e_dd;

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset_if_rsp", if_rsp_valid_o, 0);
        chk("reset_d_rsp", d_rsp_valid_o, 0);
        chk("reset_if_rdata", if_rdata_o, 0);
        chk("reset_d_rdata", d_rdata_o, 0);
        do_reset();

        // combinational grant and mux table, evaluated in IDLE with starve_cnt=0
        vt[0] = '{1'b0,1'b0,1'b0,1'b1, 4'hF, 1'b0,1'b0,1'b0,1'b0, 4'hF, 32'h0,    32'h0};
        vt[1] = '{1'b1,1'b0,1'b0,1'b1, 4'h3, 1'b1,1'b1,1'b0,1'b0, 4'hF, 32'h1000, 32'h0};
        vt[2] = '{1'b1,1'b0,1'b1,1'b0, 4'h3, 1'b1,1'b0,1'b0,1'b0, 4'hF, 32'h1000, 32'h0};
        vt[3] = '{1'b0,1'b1,1'b1,1'b1, 4'h3, 1'b1,1'b0,1'b1,1'b1, 4'h3, 32'h2000, 32'hDEADBEEF};
        vt[4] = '{1'b0,1'b1,1'b0,1'b0, 4'h5, 1'b1,1'b0,1'b0,1'b0, 4'h5, 32'h2000, 32'hDEADBEEF};
        vt[5] = '{1'b1,1'b1,1'b1,1'b1, 4'hC, 1'b1,1'b0,1'b1,1'b1, 4'hC, 32'h2000, 32'hDEADBEEF};
        vt[6] = '{1'b1,1'b1,1'b0,1'b0, 4'hF, 1'b1,1'b0,1'b0,1'b0, 4'hF, 32'h2000, 32'hDEADBEEF};
        if_addr_i = 32'h1000; d_addr_i = 32'h2000; d_wdata_i = 32'hDEADBEEF;
        for (int i = 0; i < 7; i++) begin
            if_req_valid_i = vt[i].ifv; d_req_valid_i = vt[i].dv; d_we_i = vt[i].we;
            d_be_i = vt[i].be; mem_req_ready_i = vt[i].rdy;
            settle();
            chk($sformatf("vec%0d_valid", i), mem_req_valid_o, vt[i].e_valid);
            chk($sformatf("vec%0d_if_ready", i), if_req_ready_o, vt[i].e_ifr);
            chk($sformatf("vec%0d_d_ready", i), d_req_ready_o, vt[i].e_dr);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_we", i), mem_we_o, vt[i].e_we);
                chk($sformatf("vec%0d_be", i), mem_be_o, vt[i].e_be);
                chk($sformatf("vec%0d_addr", i), mem_addr_o, vt[i].e_addr);
                chk($sformatf("vec%0d_wdata", i), mem_wdata_o, vt[i].e_wdata);
            end
        end

        // fetch only, latency 2
        do_reset();
        if_req_valid_i = 1'b1; if_addr_i = 32'h100; mem_req_ready_i = 1'b1;
        settle();
        chk("f_addr", mem_addr_o, 32'h100);
        chk("f_ready", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 1'b0;
        settle();
        chk("f_busy_novalid", mem_req_valid_o, 0);
        tick();
        respond(32'hCAFE0001);
        chk("f_rsp_pulse", if_rsp_valid_o, 1);
        chk("f_rdata", if_rdata_o, 32'hCAFE0001);
        chk("f_no_d_rsp", d_rsp_valid_o, 0);
        tick();
        chk("f_rsp_single", if_rsp_valid_o, 0);

        // starvation: four data grants then fetch, then data again
        do_reset();
        if_req_valid_i = 1'b1; if_addr_i = 32'h1000;
        d_req_valid_i = 1'b1; d_addr_i = 32'h2000; mem_req_ready_i = 1'b1;
        for (int g = 0; g < 6; g++) begin
            settle();
            chk($sformatf("starve_g%0d_if", g), if_req_ready_o, (g == LIM) ? 1 : 0);
            chk($sformatf("starve_g%0d_d", g), d_req_ready_o, (g == LIM) ? 0 : 1);
            tick();
            respond(32'h0);
        end

        // data store with partial byte enables
        do_reset();
        d_req_valid_i = 1'b1; d_addr_i = 32'h40; d_we_i = 1'b1; d_be_i = 4'b0011;
        d_wdata_i = 32'h12345678; mem_req_ready_i = 1'b1;
        settle();
        chk("st_we", mem_we_o, 1);
        chk("st_be", mem_be_o, 4'b0011);
        chk("st_addr", mem_addr_o, 32'h40);
        chk("st_wdata", mem_wdata_o, 32'h12345678);
        tick();
        d_req_valid_i = 1'b0;
        respond(32'h0);
        chk("st_rsp", d_rsp_valid_o, 1);
        chk("st_no_if_rsp", if_rsp_valid_o, 0);
        tick();
        chk("st_rsp_single", d_rsp_valid_o, 0);

        // flush while fetch outstanding, then a fresh fetch
        do_reset();
        if_req_valid_i = 1'b1; if_addr_i = 32'h180; mem_req_ready_i = 1'b1;
        tick();
        if_req_valid_i = 1'b0; if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0;
        respond(32'hBAD0BAD0);
        chk("fl_dropped", if_rsp_valid_o, 0);
        chk("fl_rdata_held", if_rdata_o, 0);
        if_req_valid_i = 1'b1; if_addr_i = 32'h200;
        settle();
        chk("fl_next_addr", mem_addr_o, 32'h200);
        tick();
        if_req_valid_i = 1'b0;
        respond(32'h600D600D);
        chk("fl_next_rsp", if_rsp_valid_o, 1);
        chk("fl_next_rdata", if_rdata_o, 32'h600D600D);

        // flush in the same cycle as the response still drops it
        if_req_valid_i = 1'b1; if_addr_i = 32'h204;
        tick();
        if_req_valid_i = 1'b0; if_flush_i = 1'b1;
        respond(32'h11111111);
        if_flush_i = 1'b0;
        chk("fl_same_cycle", if_rsp_valid_o, 0);

        // memory back-pressure with both requesting
        do_reset();
        if_req_valid_i = 1'b1; if_addr_i = 32'h400;
        d_req_valid_i = 1'b1; d_addr_i = 32'h300; mem_req_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("bp%0d_valid", c), mem_req_valid_o, 1);
            chk($sformatf("bp%0d_if_ready", c), if_req_ready_o, 0);
            chk($sformatf("bp%0d_d_ready", c), d_req_ready_o, 0);
            chk($sformatf("bp%0d_addr", c), mem_addr_o, 32'h300);
            tick();
        end
        mem_req_ready_i = 1'b1;
        settle();
        chk("bp_d_issue", d_req_ready_o, 1);
        chk("bp_if_wait", if_req_ready_o, 0);
        tick();
        chk("bp_busy", mem_req_valid_o, 0);
        chk("bp_busy_if_ready", if_req_ready_o, 0);

        // reset in BUSY abandons the transaction
        do_reset();
        if_req_valid_i = 1'b1; if_addr_i = 32'h100; mem_req_ready_i = 1'b1;
        tick();
        if_req_valid_i = 1'b0;
        respond(32'hAAAA5555);
        chk("rb_first_rdata", if_rdata_o, 32'hAAAA5555);
        if_req_valid_i = 1'b1;
        tick();
        if_req_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rb_rdata_cleared", if_rdata_o, 0);
        chk("rb_if_rsp", if_rsp_valid_o, 0);
        chk("rb_d_rsp", d_rsp_valid_o, 0);
        tick();
        rst = 1'b0;
        respond(32'h77777777);
        chk("rb_late_ignored", if_rsp_valid_o, 0);
        chk("rb_late_rdata", if_rdata_o, 0);
        chk("rb_late_d", d_rsp_valid_o, 0);
        if_req_valid_i = 1'b1;
        settle();
        chk("rb_idle_valid", mem_req_valid_o, 1);
        chk("rb_idle_ready", if_req_ready_o, 1);

        // randomized traffic against the transaction model
        do_reset();
        m_busy = 0; m_owner = 0; m_starve = 0; m_drop = 0; mo = 0; lat = 0;
        e_ifp = 1'b0; e_dp = 1'b0; e_ifd = '0; e_dd = '0; if_hold = 1'b0; d_hold = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!if_hold) begin
                if_req_valid_i = $urandom_range(0, 2) != 0;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_hold) begin
                d_req_valid_i = $urandom_range(0, 1) != 0;
                d_addr_i = $urandom;
                d_wdata_i = $urandom;
                d_we_i = $urandom_range(0, 1) != 0;
                d_be_i = 4'($urandom_range(0, 15));
            end
            mem_req_ready_i = $urandom_range(0, 3) != 0;
            if_flush_i = $urandom_range(0, 5) == 0;
            mem_rsp_valid_i = (mo != 0) && (lat == 0);
            mem_rdata_i = $urandom;
            settle();
            chk("rnd_if_rsp", if_rsp_valid_o, e_ifp);
            chk("rnd_d_rsp", d_rsp_valid_o, e_dp);
            chk("rnd_if_rdata", if_rdata_o, e_ifd);
            chk("rnd_d_rdata", d_rdata_o, e_dd);
            fw = if_req_valid_i && (!d_req_valid_i || m_starve == LIM);
            dw = d_req_valid_i && !fw;
            ev = (m_busy == 0) && (if_req_valid_i || d_req_valid_i);
            hs = ev && mem_req_ready_i;
            chk("rnd_valid", mem_req_valid_o, ev);
            chk("rnd_if_ready", if_req_ready_o, hs && fw);
            chk("rnd_d_ready", d_req_ready_o, hs && dw);
            if (ev) begin
                chk("rnd_addr", mem_addr_o, fw ? if_addr_i : d_addr_i);
                chk("rnd_we", mem_we_o, fw ? 1'b0 : d_we_i);
            end
            if_hold = if_req_valid_i && !(hs && fw);
            d_hold = d_req_valid_i && !(hs && dw);
            e_ifp = 1'b0;
            e_dp = 1'b0;
            if (m_busy == 0) begin
                if (hs) begin
                    m_busy = 1;
                    m_owner = fw ? 0 : 1;
                    if (fw) m_starve = 0;
                    else if (if_req_valid_i) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
                    mo = 1;
                    lat = $urandom_range(0, 3);
                end
            end else begin
                if (m_owner == 0 && if_flush_i) m_drop = 1;
                if (mem_rsp_valid_i) begin
                    m_busy = 0;
                    mo = 0;
                    if (m_owner == 1) begin
                        e_dp = 1'b1;
                        e_dd = mem_rdata_i;
                    end else if (m_drop == 0) begin
                        e_ifp = 1'b1;
                        e_ifd = mem_rdata_i;
                    end
                    m_drop = 0;
                end else if (lat > 0) begin
                    lat--;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost fetch cycles before fetch is forced to win.
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req_valid_i / if_req_ready_o  in/out  1/1  fetch request handshake.
REQ-006 if_addr_i  input  XLEN  fetch address, word aligned.
REQ-007 if_rsp_valid_o / if_rdata_o  out/out  1/XLEN  fetch response.
REQ-008 if_flush_i  input  1  branch taken: discard any outstanding fetch response.
REQ-009 d_req_valid_i / d_req_ready_o  in/out  1/1  load/store request handshake.
REQ-010 d_addr_i, d_wdata_i  input  XLEN  data address and write data; d_we_i (1) write enable; d_be_i (4) byte enables.
REQ-011 d_rsp_valid_o / d_rdata_o  out/out  1/XLEN  data response; writes also return one response.
REQ-012 mem_req_valid_o / mem_req_ready_i  out/in  1/1; mem_addr_o, mem_wdata_o (XLEN), mem_we_o (1), mem_be_o (4): single shared memory port.
REQ-013 mem_rsp_valid_i / mem_rdata_i  in/in  1/XLEN  memory response, exactly one per accepted request.

Function
REQ-014 Two states, IDLE and BUSY; at most one memory request outstanding.
REQ-015 IDLE: mem_req_valid_o = if_req_valid_i | d_req_valid_i; request fields muxed combinationally from the winner.
REQ-016 Priority: data wins over fetch unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-017 Fetch request fields: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-018 Winner's ready = IDLE & mem_req_ready_i; loser's ready = 0; both readies are 0 in BUSY.
REQ-019 On handshake (mem_req_valid_o & mem_req_ready_i): latch owner (IF/D), go to BUSY next cycle.
REQ-020 starve_cnt: +1 on each data grant while if_req_valid_i=1, saturating at STARVE_LIMIT; cleared on fetch grant; held otherwise.
REQ-021 BUSY: mem_req_valid_o=0; on mem_rsp_valid_i return to IDLE next cycle; a new request may issue in that cycle.
REQ-022 Responses registered: owner's rsp_valid_o is a one-cycle pulse the cycle after mem_rsp_valid_i; rdata_o loaded with mem_rdata_i at the same edge, held otherwise.
REQ-023 if_flush_i in BUSY with owner=IF (including the cycle of mem_rsp_valid_i) sets drop flag; the response is consumed and if_rsp_valid_o stays 0; flag cleared on return to IDLE.
REQ-024 if_flush_i in IDLE or with owner=D: no effect; a fetch request presented in the same cycle as flush is arbitrated normally.
REQ-025 mem_rsp_valid_i while in IDLE is ignored.
REQ-026 Requesters hold request fields stable while valid & !ready; the arbiter does not register request fields.

Reset
REQ-027 rst asserted: state=IDLE, owner=IF, starve_cnt=0, drop flag=0, if_rsp_valid_o=0, d_rsp_valid_o=0, if_rdata_o=0, d_rdata_o=0.
REQ-028 Reset during BUSY abandons the outstanding transaction; its late response is ignored per REQ-025.

Structure
REQ-029 Shared package core_pkg holds XLEN, the state enum (IDLE, BUSY) and the owner encoding (OWN_IF, OWN_D).
REQ-030 Single flat module; no sub-module; grant logic, counter and FSM inline.

Verification
REQ-031 Fetch only, addr 0x100, memory latency 2 -> if_rsp_valid_o pulses once with mem_rdata_i; d_rsp_valid_o stays 0.
REQ-032 Both valid from reset, continuous data requests -> data granted 4 times, 5th grant to fetch, starve_cnt back to 0.
REQ-033 Data store addr 0x40, be=4'b0011 -> mem_we_o=1, mem_be_o=4'b0011 on port; d_rsp_valid_o pulses once.
REQ-034 if_flush_i pulsed while fetch outstanding -> no if_rsp_valid_o; next fetch to 0x200 completes normally.
REQ-035 mem_req_ready_i=0 for 3 cycles with both valid -> both readies 0, state stays IDLE, fields stable, data issued on cycle ready=1.
REQ-036 rst asserted in BUSY, memory responds after reset -> all outputs at reset values, no rsp_valid pulse.
